uart_fifo: RTL and testbench

Parametrised successor to the team's 8N1 UART. Adds configurable data width, bit period, parity and stop-bit count, plus an RX FIFO so back-to-back frames are not lost while software is slow to acknowledge. Sits between the board-level rx/tx pins and the internal byte-stream logic. The start/ready and rcvd/rxack handshakes keep the same semantics as the existing uart, so current users drop in unchanged.

---
 rtl/uart_fifo.sv | 381 ++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// uart_fifo: parametrised UART with a show-ahead RX FIFO.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits.
// The RX and TX state machines run independently of each other.
// Optional feature macro: UART_LOOPBACK_EN adds a 'loopback' input. When it is high the
// receiver listens to the internal transmit stream and the tx pin is held at 1.

module uart_fifo #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned CLKS_PER_BIT  = 10,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  tx,
  input  logic [DATA_WIDTH-1:0] datatx,
  input  logic                  start,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] datarx,
  output logic                  rcvd,
  input  logic                  rxack,
  output logic                  rx_err,
  output logic                  parity_err,
  output logic                  overrun,
  input  logic                  err_clr
`ifdef UART_LOOPBACK_EN
  ,
  input  logic                  loopback
`endif
);

  localparam int unsigned CntW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW   = $clog2(DATA_WIDTH);
  localparam int unsigned AddrW  = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned CountW = AddrW + 1;

  localparam logic [CntW-1:0]   BitEnd    = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]   HalfEnd   = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BitW-1:0]   LastBit   = BitW'(DATA_WIDTH - 1);
  localparam logic              LastStop  = 1'(STOP_BITS - 1);
  localparam logic              OddPar    = (PARITY == 2);
  localparam bit                HasParity = (PARITY != 0);
  localparam logic [CountW-1:0] FullCount = CountW'(RX_FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // ---------------------------------------------------------------------------
  // Loopback selection
  // ---------------------------------------------------------------------------
  logic tx_int;
  logic rx_src;

`ifdef UART_LOOPBACK_EN
  logic loopback_q;

  // Register the loopback control so a change takes effect on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      loopback_q <= 1'b0;
    end else begin
      loopback_q <= loopback;
    end
  end

  assign rx_src = loopback_q ? tx_int : rx;
  assign tx     = tx_int | loopback_q;
`else
  assign rx_src = rx;
  assign tx     = tx_int;
`endif

  // ---------------------------------------------------------------------------
  // RX synchroniser
  // ---------------------------------------------------------------------------
  logic rx_meta_q;
  logic rxs_q;
  logic rxs_prev_q;
  logic rx_fall;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx_src;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Requiring a 1 -> 0 transition means a line stuck low never retriggers a frame.
  assign rx_fall = !rxs_q && rxs_prev_q;

  // ---------------------------------------------------------------------------
  // RX state machine
  // ---------------------------------------------------------------------------
  state_e                rx_state_q, rx_state_d;
  logic [CntW-1:0]       rx_cnt_q, rx_cnt_d;
  logic [BitW-1:0]       rx_bit_q, rx_bit_d;
  logic                  rx_stop_q, rx_stop_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                  rx_bit_end;
  logic                  rx_push;
  logic                  rx_ferr_set;
  logic                  rx_perr_set;

  assign rx_bit_end = (rx_cnt_q == BitEnd);

  // RX state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_stop_q  <= 1'b0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_stop_q  <= rx_stop_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // RX next state: half-bit wait to centre on the start bit, then full-bit sample steps.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CntW'(1);
    rx_bit_d   = rx_bit_q;
    rx_stop_d  = rx_stop_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      StIdle: begin
        rx_cnt_d = '0;
        if (rx_fall) begin
          rx_state_d = StStart;
        end
      end
      StStart: begin
        if (rx_cnt_q == HalfEnd) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          // A line back high at mid start bit was a glitch.
          rx_state_d = rxs_q ? StIdle : StData;
        end
      end
      StData: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxs_q, rx_shift_q[DATA_WIDTH-1:1]};
          rx_bit_d   = rx_bit_q + BitW'(1);
          if (rx_bit_q == LastBit) begin
            rx_stop_d  = 1'b0;
            rx_state_d = HasParity ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_state_d = StStop;
        end
      end
      StStop: begin
        if (rx_bit_end) begin
          rx_cnt_d = '0;
          // A bad stop bit abandons the frame without checking later stop bits.
          if (!rxs_q || (rx_stop_q == LastStop)) begin
            rx_state_d = StIdle;
          end else begin
            rx_stop_d = 1'b1;
          end
        end
      end
      default: begin
        rx_state_d = StIdle;
      end
    endcase
  end

  // RX event strobes: push, framing error and parity error at their sample points.
  always_comb begin
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    rx_perr_set = 1'b0;
    if ((rx_state_q == StParity) && rx_bit_end) begin
      rx_perr_set = (rxs_q != ((^rx_shift_q) ^ OddPar));
    end
    if ((rx_state_q == StStop) && rx_bit_end) begin
      if (!rxs_q) begin
        rx_ferr_set = 1'b1;
      end else if (rx_stop_q == LastStop) begin
        rx_push = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [RX_FIFO_DEPTH];
  logic [AddrW-1:0]      wr_ptr_q;
  logic [AddrW-1:0]      rd_ptr_q;
  logic [CountW-1:0]     count_q;
  logic                  rxack_q;
  logic                  fifo_full;
  logic                  pop;
  logic                  push_ok;
  logic                  overrun_set;

  assign fifo_full   = (count_q == FullCount);
  assign rcvd        = (count_q != '0);
  assign pop         = rxack && !rxack_q && rcvd;
  // A same-cycle pop frees a slot, so a push into a full FIFO still succeeds.
  assign push_ok     = rx_push && (!fifo_full || pop);
  assign overrun_set = rx_push && fifo_full && !pop;
  assign datarx      = rcvd ? mem_q[rd_ptr_q] : '0;

  // Registered copy of rxack; reset high so an ack held through reset does not pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxack_q <= 1'b1;
    end else begin
      rxack_q <= rxack;
    end
  end

  // FIFO storage; contents are only visible through a valid read pointer.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= rx_shift_q;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      if (push_ok && !pop) begin
        count_q <= count_q + CountW'(1);
      end else if (pop && !push_ok) begin
        count_q <= count_q - CountW'(1);
      end
    end
  end

  // Sticky error flags; clearing beats a same-cycle set.
  always_ff @(posedge clk) begin
    if (reset || err_clr) begin
      rx_err     <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_err     <= rx_err | rx_ferr_set;
      parity_err <= parity_err | rx_perr_set;
      overrun    <= overrun | overrun_set;
    end
  end

  // ---------------------------------------------------------------------------
  // TX state machine
  // ---------------------------------------------------------------------------
  state_e                tx_state_q, tx_state_d;
  logic [CntW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [BitW-1:0]       tx_bit_q, tx_bit_d;
  logic                  tx_stop_q, tx_stop_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == BitEnd);

  // TX state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_stop_q  <= tx_stop_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  // TX next state: each frame element is held for one full bit period.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CntW'(1);
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        if (start) begin
          tx_state_d = StStart;
          tx_shift_d = datatx;
          tx_par_d   = (^datatx) ^ OddPar;
        end
      end
      StStart: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = StData;
        end
      end
      StData: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
          tx_bit_d   = tx_bit_q + BitW'(1);
          if (tx_bit_q == LastBit) begin
            tx_stop_d  = 1'b0;
            tx_state_d = HasParity ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = StStop;
        end
      end
      StStop: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_stop_q == LastStop) begin
            tx_state_d = StIdle;
          end else begin
            tx_stop_d = 1'b1;
          end
        end
      end
      default: begin
        tx_state_d = StIdle;
      end
    endcase
  end

  // TX outputs decoded from the current state.
  always_comb begin
    ready  = (tx_state_q == StIdle);
    tx_int = 1'b1;
    case (tx_state_q)
      StStart:  tx_int = 1'b0;
      StData:   tx_int = tx_shift_q[0];
      StParity: tx_int = tx_par_q;
      default:  tx_int = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: default 8N1 instance plus even- and odd-parity instances.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_uart_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Default instance (8 data, no parity, 1 stop, 10 clk/bit, depth 4)
  logic       d_rx, d_tx, d_start, d_ready, d_rcvd, d_rxack, d_rx_err, d_perr, d_ovr, d_err_clr;
  logic [7:0] d_datatx, d_datarx;
  // Even parity instance
  logic       e_rx, e_tx, e_start, e_ready, e_rcvd, e_rxack, e_rx_err, e_perr, e_ovr, e_err_clr;
  logic [7:0] e_datatx, e_datarx;
  // Odd parity instance
  logic       o_rx, o_tx, o_start, o_ready, o_rcvd, o_rxack, o_rx_err, o_perr, o_ovr, o_err_clr;
  logic [7:0] o_datatx, o_datarx;
`ifdef UART_LOOPBACK_EN
  logic       loopback;
`endif

  int n_cmp = 0;
  int n_err = 0;

  uart_fifo u_def (
    .clk        (clk),
    .reset      (reset),
    .rx         (d_rx),
    .tx         (d_tx),
    .datatx     (d_datatx),
    .start      (d_start),
    .ready      (d_ready),
    .datarx     (d_datarx),
    .rcvd       (d_rcvd),
    .rxack      (d_rxack),
    .rx_err     (d_rx_err),
    .parity_err (d_perr),
    .overrun    (d_ovr),
    .err_clr    (d_err_clr)
`ifdef UART_LOOPBACK_EN
    ,
    .loopback   (loopback)
`endif
  );

  uart_fifo #(.PARITY(1)) u_even (
    .clk        (clk),
    .reset      (reset),
    .rx         (e_rx),
    .tx         (e_tx),
    .datatx     (e_datatx),
    .start      (e_start),
    .ready      (e_ready),
    .datarx     (e_datarx),
    .rcvd       (e_rcvd),
    .rxack      (e_rxack),
    .rx_err     (e_rx_err),
    .parity_err (e_perr),
    .overrun    (e_ovr),
    .err_clr    (e_err_clr)
`ifdef UART_LOOPBACK_EN
    ,
    .loopback   (1'b0)
`endif
  );

  uart_fifo #(.PARITY(2)) u_odd (
    .clk        (clk),
    .reset      (reset),
    .rx         (o_rx),
    .tx         (o_tx),
    .datatx     (o_datatx),
    .start      (o_start),
    .ready      (o_ready),
    .datarx     (o_datarx),
    .rcvd       (o_rcvd),
    .rxack      (o_rxack),
    .rx_err     (o_rx_err),
    .parity_err (o_perr),
    .overrun    (o_ovr),
    .err_clr    (o_err_clr)
`ifdef UART_LOOPBACK_EN
    ,
    .loopback   (1'b0)
`endif
  );

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    logic       exp_rcvd;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } rx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_bits;  // bit i = i-th bit on the line (start first)
  } tx_vec_t;

  rx_vec_t rxv [5];
  tx_vec_t txv [3];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, want %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) d_rx = v;
    else e_rx = v;
  endtask

  // Drive one frame onto the chosen rx line; pmode 0 none, 1 even, 2 odd.
  task automatic rx_frame(input int which, input logic [7:0] d, input int pmode,
                          input logic flip, input logic stop_v);
    logic p;
    set_rx(which, 1'b0);
    tick(10);
    for (int i = 0; i < 8; i++) begin
      set_rx(which, d[i]);
      tick(10);
    end
    if (pmode != 0) begin
      p = (^d) ^ (pmode == 2) ^ flip;
      set_rx(which, p);
      tick(10);
    end
    set_rx(which, stop_v);
    tick(10);
    set_rx(which, 1'b1);
  endtask

  task automatic pop(input int which);
    if (which == 0) d_rxack = 1'b1;
    else e_rxack = 1'b1;
    tick(1);
    d_rxack = 1'b0;
    e_rxack = 1'b0;
    tick(1);
  endtask

  task automatic clear_flags();
    d_err_clr = 1'b1;
    e_err_clr = 1'b1;
    tick(1);
    d_err_clr = 1'b0;
    e_err_clr = 1'b0;
  endtask

  initial begin
    rxv[0] = '{8'h8E, 1'b1, 1'b1, 8'h8E, 1'b0};
    rxv[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    rxv[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    rxv[3] = '{8'h55, 1'b0, 1'b0, 8'h00, 1'b1};
    rxv[4] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b0};
    txv[0] = '{8'hED, 10'h3DA};
    txv[1] = '{8'h01, 10'h202};
    txv[2] = '{8'hA5, 10'h34A};

    reset = 1'b1;
    d_rx = 1'b1; d_start = 1'b0; d_datatx = 8'h00; d_rxack = 1'b0; d_err_clr = 1'b0;
    e_rx = 1'b1; e_start = 1'b0; e_datatx = 8'h00; e_rxack = 1'b0; e_err_clr = 1'b0;
    o_rx = 1'b1; o_start = 1'b0; o_datatx = 8'h00; o_rxack = 1'b0; o_err_clr = 1'b0;
`ifdef UART_LOOPBACK_EN
    loopback = 1'b0;
`endif
    tick(3);

    // Reset values
    chk1("rst_tx", d_tx, 1'b1);
    chk1("rst_ready", d_ready, 1'b1);
    chk1("rst_rcvd", d_rcvd, 1'b0);
    chk8("rst_datarx", d_datarx, 8'h00);
    chk1("rst_rx_err", d_rx_err, 1'b0);
    chk1("rst_perr", d_perr, 1'b0);
    chk1("rst_ovr", d_ovr, 1'b0);
    chk1("rst_e_rcvd", e_rcvd, 1'b0);
    chk1("rst_o_rcvd", o_rcvd, 1'b0);
    chk1("rst_o_flags", o_rx_err | o_perr | o_ovr | e_rx_err | e_perr | e_ovr, 1'b0);
    chk8("rst_o_datarx", o_datarx | e_datarx, 8'h00);
    reset = 1'b0;
    tick(2);

    // RX table on the default instance
    for (int i = 0; i < 5; i++) begin
      rx_frame(0, rxv[i].data, 0, 1'b0, rxv[i].stop_v);
      tick(2);
      chk1("rx_rcvd", d_rcvd, rxv[i].exp_rcvd);
      if (rxv[i].exp_rcvd) chk8("rx_data", d_datarx, rxv[i].exp_data);
      chk1("rx_ferr", d_rx_err, rxv[i].exp_ferr);
      chk1("rx_perr", d_perr, 1'b0);
      chk1("rx_ovr", d_ovr, 1'b0);
      if (rxv[i].exp_rcvd) pop(0);
      clear_flags();
      tick(1);
      chk1("rx_empty_after", d_rcvd, 1'b0);
      chk1("rx_ferr_cleared", d_rx_err, 1'b0);
    end

    // Held rxack pops exactly one word
    rx_frame(0, 8'h8E, 0, 1'b0, 1'b1);
    rx_frame(0, 8'h3C, 0, 1'b0, 1'b1);
    tick(2);
    chk1("hold_pre_rcvd", d_rcvd, 1'b1);
    chk8("hold_pre_data", d_datarx, 8'h8E);
    d_rxack = 1'b1;
    tick(10);
    chk1("hold_one_pop_rcvd", d_rcvd, 1'b1);
    chk8("hold_one_pop_data", d_datarx, 8'h3C);
    d_rxack = 1'b0;
    tick(1);
    pop(0);
    chk1("hold_final_empty", d_rcvd, 1'b0);

    // TX table on the default instance, with an ignored mid-frame start
    for (int i = 0; i < 3; i++) begin
      chk1("tx_ready_pre", d_ready, 1'b1);
      d_datatx = txv[i].data;
      d_start = 1'b1;
      tick(1);
      d_start = 1'b0;
      for (int k = 0; k < 100; k++) begin
        chk1("tx_bit", d_tx, txv[i].exp_bits[k/10]);
        chk1("tx_busy", d_ready, 1'b0);
        if (k == 49) begin
          d_start = 1'b1;
          d_datatx = ~txv[i].data;
        end else begin
          d_start = 1'b0;
        end
        tick(1);
      end
      for (int k = 0; k < 5; k++) begin
        chk1("tx_ready_post", d_ready, 1'b1);
        chk1("tx_idle_post", d_tx, 1'b1);
        tick(1);
      end
    end

    // TX parity: 8'hED has six ones
    e_datatx = 8'hED; o_datatx = 8'hED;
    e_start = 1'b1; o_start = 1'b1;
    tick(1);
    e_start = 1'b0; o_start = 1'b0;
    chk1("par_start_bit", e_tx, 1'b0);
    tick(94);
    chk1("par_even_bit", e_tx, 1'b0);
    chk1("par_odd_bit", o_tx, 1'b1);
    tick(10);
    chk1("par_even_stop", e_tx, 1'b1);
    chk1("par_odd_stop", o_tx, 1'b1);
    tick(5);
    chk1("par_busy_end", e_ready, 1'b0);
    tick(1);
    chk1("par_even_ready", e_ready, 1'b1);
    chk1("par_odd_ready", o_ready, 1'b1);

    // RX parity on the even instance: correct, then flipped
    rx_frame(1, 8'hED, 1, 1'b0, 1'b1);
    tick(2);
    chk1("rxpar_ok_rcvd", e_rcvd, 1'b1);
    chk8("rxpar_ok_data", e_datarx, 8'hED);
    chk1("rxpar_ok_perr", e_perr, 1'b0);
    pop(1);
    rx_frame(1, 8'hED, 1, 1'b1, 1'b1);
    tick(2);
    chk1("rxpar_bad_perr", e_perr, 1'b1);
    chk1("rxpar_bad_rcvd", e_rcvd, 1'b1);
    chk8("rxpar_bad_data", e_datarx, 8'hED);
    chk1("rxpar_bad_ferr", e_rx_err, 1'b0);
    pop(1);
    clear_flags();
    tick(1);
    chk1("rxpar_cleared", e_perr, 1'b0);
    chk1("rxpar_empty", e_rcvd, 1'b0);

    // Overrun: five back-to-back frames into a four-deep FIFO
    for (int i = 0; i < 5; i++) begin
      rx_frame(0, 8'(i + 1), 0, 1'b0, 1'b1);
      chk1("ovr_flag", d_ovr, (i == 4));
    end
    tick(1);
    for (int i = 0; i < 4; i++) begin
      chk1("ovr_pop_rcvd", d_rcvd, 1'b1);
      chk8("ovr_pop_data", d_datarx, 8'(i + 1));
      pop(0);
    end
    chk1("ovr_drained", d_rcvd, 1'b0);
    chk1("ovr_sticky", d_ovr, 1'b1);
    clear_flags();
    tick(1);
    chk1("ovr_cleared", d_ovr, 1'b0);

    // Three-cycle glitch on idle rx, then a normal frame
    d_rx = 1'b0;
    tick(3);
    d_rx = 1'b1;
    tick(30);
    chk1("glitch_rcvd", d_rcvd, 1'b0);
    chk1("glitch_ferr", d_rx_err, 1'b0);
    chk1("glitch_perr", d_perr, 1'b0);
    rx_frame(0, 8'h5A, 0, 1'b0, 1'b1);
    tick(2);
    chk1("post_glitch_rcvd", d_rcvd, 1'b1);
    chk8("post_glitch_data", d_datarx, 8'h5A);

    // Reset mid TX and mid RX frame, with a word still in the FIFO
    d_datatx = 8'h00;
    d_start = 1'b1;
    tick(1);
    d_start = 1'b0;
    d_rx = 1'b0;
    tick(40);
    chk1("midrst_pre_tx", d_tx, 1'b0);
    chk1("midrst_pre_ready", d_ready, 1'b0);
    reset = 1'b1;
    d_rx = 1'b1;
    tick(1);
    chk1("midrst_tx", d_tx, 1'b1);
    chk1("midrst_ready", d_ready, 1'b1);
    chk1("midrst_rcvd", d_rcvd, 1'b0);
    chk8("midrst_datarx", d_datarx, 8'h00);
    reset = 1'b0;
    tick(120);
    chk1("midrst_after_rcvd", d_rcvd, 1'b0);
    chk1("midrst_after_ferr", d_rx_err, 1'b0);
    chk1("midrst_after_tx", d_tx, 1'b1);

`ifdef UART_LOOPBACK_EN
    // Loopback: transmitted word arrives in the RX FIFO, tx pin stays high
    loopback = 1'b1;
    tick(1);
    d_datatx = 8'hA5;
    d_start = 1'b1;
    tick(1);
    d_start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      chk1("lb_tx_pin", d_tx, 1'b1);
      tick(5);
    end
    chk1("lb_rcvd", d_rcvd, 1'b1);
    chk8("lb_data", d_datarx, 8'hA5);
    chk1("lb_ferr", d_rx_err, 1'b0);
    loopback = 1'b0;
    tick(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
